io_loader: RTL and testbench

- Writer-side companion of the instruction/data memory mux: the IO initiator that drives the mux's IO port (addr_io/data_io/we_io) and owns io_sel.
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and writes them to consecutive memory addresses.
- Holds io_sel high from reset until the whole image is written, then releases memory to the processor and signals done.

---
 rtl/io_loader_pkg.sv | 16 +
 rtl/io_loader_byte_assembler.sv | 42 ++++
 rtl/io_loader.sv | 146 ++++++++++++++
 tb/tb_io_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_loader_pkg.sv
// Shared definitions for the IO image loader and the processor boot logic.
package io_loader_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Image base and stride; the processor boot PC reuses the base.
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_ADDR_STEP = 32'd4;

endpackage

// File: rtl/io_loader_byte_assembler.sv
// Little-endian 8-to-32 packer; word_o/word_valid_o reflect the byte accepted this cycle.
module io_loader_byte_assembler
  import io_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_valid_o = 1'b0;
    if (clear_i) begin
      idx_d = 2'd0;
      asm_d = '0;
    end else if (byte_valid_i) begin
      asm_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                       = idx_q + 2'd1;
      word_valid_o                = (idx_q == 2'(BYTES_PER_WORD - 1));
    end
    word_o = asm_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= 2'd0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/io_loader.sv
// Loads a length-prefixed little-endian word image from a byte stream into memory via the IO port.
module io_loader
  import io_loader_pkg::*;
#(
  parameter int unsigned      ADDRW     = 32,
  parameter int unsigned      DATAW     = 32,
  parameter logic [ADDRW-1:0] BASE_ADDR = ADDRW'(DEF_BASE_ADDR),
  parameter logic [ADDRW-1:0] ADDR_STEP = ADDRW'(DEF_ADDR_STEP),
  parameter int unsigned      MAX_WORDS = 16384
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             reload,
  output logic             io_sel,
  output logic [ADDRW-1:0] addr_io,
  output logic [DATAW-1:0] data_io,
  output logic             we_io,
  output logic             done,
  output logic             overflow,
  output logic [ADDRW-1:0] words_written
);

  state_e           state_q, state_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [ADDRW-1:0] addr_io_q, addr_io_d;
  logic [DATAW-1:0] data_io_q, data_io_d;
  logic             we_io_q, we_io_d;
  logic             io_sel_q, io_sel_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [ADDRW-1:0] words_written_q, words_written_d;

  logic        byte_valid;
  logic [31:0] word;
  logic        word_valid;

  // Bytes arriving after the image or alongside reload are dropped.
  assign byte_valid = rx_valid && !reload && (state_q != S_DONE);

  io_loader_byte_assembler u_asm (
    .clk_i        (clk),
    .rst_ni       (rstn),
    .clear_i      (reload),
    .byte_valid_i (byte_valid),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    word_cnt_d      = word_cnt_q;
    wr_addr_d       = wr_addr_q;
    addr_io_d       = addr_io_q;
    data_io_d       = data_io_q;
    we_io_d         = 1'b0;
    io_sel_d        = io_sel_q;
    done_d          = done_q;
    overflow_d      = overflow_q;
    words_written_d = words_written_q;
    if (reload) begin
      state_d         = S_LEN;
      len_d           = '0;
      word_cnt_d      = '0;
      wr_addr_d       = BASE_ADDR;
      addr_io_d       = BASE_ADDR;
      data_io_d       = '0;
      io_sel_d        = 1'b1;
      done_d          = 1'b0;
      overflow_d      = 1'b0;
      words_written_d = '0;
    end else begin
      case (state_q)
        S_LEN: begin
          if (word_valid) begin
            len_d      = word;
            overflow_d = (word > MAX_WORDS);
            state_d    = (word == 32'd0) ? S_DONE : S_DATA;
          end
        end
        S_DATA: begin
          if (word_valid) begin
            word_cnt_d = word_cnt_q + 32'd1;
            // Words past capacity still count toward len but are never written.
            if (word_cnt_q < MAX_WORDS) begin
              we_io_d         = 1'b1;
              data_io_d       = DATAW'(word);
              addr_io_d       = wr_addr_q;
              wr_addr_d       = wr_addr_q + ADDR_STEP;
              words_written_d = words_written_q + ADDRW'(1);
            end
            if (word_cnt_d == len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          // Entered on the final write edge, so the release lands one cycle after it.
          io_sel_d = 1'b0;
          done_d   = 1'b1;
        end
        default: state_d = S_LEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_LEN;
      len_q           <= '0;
      word_cnt_q      <= '0;
      wr_addr_q       <= BASE_ADDR;
      addr_io_q       <= BASE_ADDR;
      data_io_q       <= '0;
      we_io_q         <= 1'b0;
      io_sel_q        <= 1'b1;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      word_cnt_q      <= word_cnt_d;
      wr_addr_q       <= wr_addr_d;
      addr_io_q       <= addr_io_d;
      data_io_q       <= data_io_d;
      we_io_q         <= we_io_d;
      io_sel_q        <= io_sel_d;
      done_q          <= done_d;
      overflow_q      <= overflow_d;
      words_written_q <= words_written_d;
    end
  end

  assign io_sel        = io_sel_q;
  assign addr_io       = addr_io_q;
  assign data_io       = data_io_q;
  assign we_io         = we_io_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_io_loader.sv
// Directed bench for io_loader: a default instance plus a MAX_WORDS=2 instance on the same stream.
module tb_io_loader;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;

  logic        io_sel, we_io, done, overflow;
  logic [31:0] addr_io, data_io, words_written;
  logic        o_io_sel, o_we_io, o_done, o_overflow;
  logic [31:0] o_addr_io, o_data_io, o_words_written;

  int checks;
  int failures;

  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic [31:0] oqa[$];
  logic [31:0] oqd[$];

  io_loader dut (
    .clk           (clk),
    .rstn          (rstn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .reload        (reload),
    .io_sel        (io_sel),
    .addr_io       (addr_io),
    .data_io       (data_io),
    .we_io         (we_io),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  io_loader #(.MAX_WORDS(2)) dut_ov (
    .clk           (clk),
    .rstn          (rstn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .reload        (reload),
    .io_sel        (o_io_sel),
    .addr_io       (o_addr_io),
    .data_io       (o_data_io),
    .we_io         (o_we_io),
    .done          (o_done),
    .overflow      (o_overflow),
    .words_written (o_words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_io) begin
      qa.push_back(addr_io);
      qd.push_back(data_io);
    end
    if (o_we_io) begin
      oqa.push_back(o_addr_io);
      oqd.push_back(o_data_io);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap) idle();
    end
  endtask

  task automatic do_reload(input bit with_byte);
    reload   = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic clear_queues();
    qa.delete();
    qd.delete();
    oqa.delete();
    oqd.delete();
  endtask

  task automatic test_reset();
    checks++; if (io_sel !== 1'b1) begin failures++; $display("FAIL reset_io_sel got=%0h exp=1", io_sel); end
    checks++; if (we_io !== 1'b0) begin failures++; $display("FAIL reset_we_io got=%0h exp=0", we_io); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
    checks++; if (words_written !== 32'd0) begin failures++; $display("FAIL reset_words got=%0h exp=0", words_written); end
    checks++; if (addr_io !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", addr_io); end
    checks++; if (data_io !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_io); end
  endtask

  task automatic test_two_words();
    clear_queues();
    send_word(32'd2, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hEF >> 0 == 8'hEF && i == 0 ? 8'hEF : (i == 1 ? 8'hBE : 8'hAD));
    send_byte(8'hDE);
    checks++; if (we_io !== 1'b1) begin failures++; $display("FAIL two_we got=%0h exp=1", we_io); end
    checks++; if (addr_io !== 32'd4) begin failures++; $display("FAIL two_addr got=%0h exp=4", addr_io); end
    checks++; if (data_io !== 32'hDEAD_BEEF) begin failures++; $display("FAIL two_data got=%0h exp=deadbeef", data_io); end
    checks++; if (io_sel !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL two_last_sel got=%0h/%0h exp=1/0", io_sel, done); end
    idle();
    checks++; if (done !== 1'b1 || io_sel !== 1'b0) begin failures++; $display("FAIL two_done got=%0h/%0h exp=1/0", done, io_sel); end
    checks++; if (we_io !== 1'b0) begin failures++; $display("FAIL two_we_off got=%0h exp=0", we_io); end
    checks++;
    if (qa.size() != 2) begin
      failures++; $display("FAIL two_count got=%0d exp=2", qa.size());
    end else if (qa[0] !== 32'd0 || qd[0] !== 32'h1122_3344) begin
      failures++; $display("FAIL two_first got=%0h:%0h exp=0:11223344", qa[0], qd[0]);
    end
    checks++; if (words_written !== 32'd2) begin failures++; $display("FAIL two_words got=%0h exp=2", words_written); end
  endtask

  task automatic test_zero_len();
    do_reload(1'b0);
    checks++; if (done !== 1'b0 || io_sel !== 1'b1) begin failures++; $display("FAIL zero_reload got=%0h/%0h exp=0/1", done, io_sel); end
    checks++; if (words_written !== 32'd0) begin failures++; $display("FAIL zero_reload_words got=%0h exp=0", words_written); end
    clear_queues();
    send_word(32'd0, 1'b0);
    idle();
    checks++; if (done !== 1'b1 || io_sel !== 1'b0) begin failures++; $display("FAIL zero_done got=%0h/%0h exp=1/0", done, io_sel); end
    send_word(32'h0403_0201, 1'b0);
    send_word(32'h0807_0605, 1'b0);
    idle();
    checks++; if (qa.size() != 0) begin failures++; $display("FAIL zero_no_write got=%0d exp=0", qa.size()); end
    checks++; if (words_written !== 32'd0 || done !== 1'b1) begin failures++; $display("FAIL zero_ignored got=%0h/%0h exp=0/1", words_written, done); end
  endtask

  task automatic test_overflow();
    do_reload(1'b0);
    clear_queues();
    send_word(32'd3, 1'b1);
    send_word(32'h0102_0304, 1'b1);
    send_word(32'h0A0B_0C0D, 1'b1);
    send_word(32'hCAFE_F00D, 1'b0);
    checks++; if (o_we_io !== 1'b0) begin failures++; $display("FAIL ovf_suppressed got=%0h exp=0", o_we_io); end
    checks++; if (we_io !== 1'b1 || addr_io !== 32'd8 || data_io !== 32'hCAFE_F00D) begin failures++; $display("FAIL ovf_main_third got=%0h:%0h:%0h exp=1:8:cafef00d", we_io, addr_io, data_io); end
    idle();
    checks++; if (o_done !== 1'b1 || o_io_sel !== 1'b0) begin failures++; $display("FAIL ovf_done got=%0h/%0h exp=1/0", o_done, o_io_sel); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", o_overflow); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_main_flag got=%0h exp=0", overflow); end
    checks++; if (o_words_written !== 32'd2) begin failures++; $display("FAIL ovf_words got=%0h exp=2", o_words_written); end
    checks++;
    if (oqa.size() != 2) begin
      failures++; $display("FAIL ovf_count got=%0d exp=2", oqa.size());
    end else if (oqa[0] !== 32'd0 || oqd[0] !== 32'h0102_0304 || oqa[1] !== 32'd4 || oqd[1] !== 32'h0A0B_0C0D) begin
      failures++; $display("FAIL ovf_writes got=%0h:%0h,%0h:%0h exp=0:01020304,4:0a0b0c0d", oqa[0], oqd[0], oqa[1], oqd[1]);
    end
    checks++; if (qa.size() != 3 || words_written !== 32'd3) begin failures++; $display("FAIL ovf_main_count got=%0d/%0h exp=3/3", qa.size(), words_written); end
  endtask

  task automatic test_back_to_back();
    do_reload(1'b0);
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL b2b_reload_ovf got=%0h exp=0", o_overflow); end
    clear_queues();
    send_word(32'd1, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    checks++; if (we_io !== 1'b1 || addr_io !== 32'd0 || data_io !== 32'h1234_5678) begin failures++; $display("FAIL b2b_write got=%0h:%0h:%0h exp=1:0:12345678", we_io, addr_io, data_io); end
    idle();
    checks++; if (done !== 1'b1 || qa.size() != 1) begin failures++; $display("FAIL b2b_done got=%0h/%0d exp=1/1", done, qa.size()); end
  endtask

  task automatic test_reload_mid_word();
    do_reload(1'b0);
    clear_queues();
    send_word(32'd2, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reload(1'b1);
    send_word(32'd1, 1'b1);
    send_word(32'hDDCC_BBAA, 1'b0);
    checks++; if (we_io !== 1'b1 || addr_io !== 32'd0 || data_io !== 32'hDDCC_BBAA) begin failures++; $display("FAIL reload_write got=%0h:%0h:%0h exp=1:0:ddccbbaa", we_io, addr_io, data_io); end
    idle();
    checks++; if (qa.size() != 1 || done !== 1'b1) begin failures++; $display("FAIL reload_single got=%0d/%0h exp=1/1", qa.size(), done); end
  endtask

  task automatic test_async_reset();
    do_reload(1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'h05);
    send_byte(8'h06);
    checks++; if (words_written !== 32'd1) begin failures++; $display("FAIL arst_pre_words got=%0h exp=1", words_written); end
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (io_sel !== 1'b1 || we_io !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL arst_outputs got=%0h/%0h/%0h exp=1/0/0", io_sel, we_io, done); end
    checks++; if (words_written !== 32'd0 || data_io !== 32'd0) begin failures++; $display("FAIL arst_clear got=%0h/%0h exp=0/0", words_written, data_io); end
    @(negedge clk);
    rstn = 1'b1;
    idle();
    clear_queues();
    send_word(32'd1, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    checks++; if (we_io !== 1'b1 || addr_io !== 32'd0 || data_io !== 32'h5566_7788) begin failures++; $display("FAIL arst_reload_write got=%0h:%0h:%0h exp=1:0:55667788", we_io, addr_io, data_io); end
    idle();
    checks++; if (qa.size() != 1 || done !== 1'b1 || io_sel !== 1'b0) begin failures++; $display("FAIL arst_done got=%0d/%0h/%0h exp=1/1/0", qa.size(), done, io_sel); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    reload   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle();
    test_two_words();
    test_zero_len();
    test_overflow();
    test_back_to_back();
    test_reload_mid_word();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
